// File: rtl/read_ptr_block.sv
// Read-domain pointer and empty-flag generator for an asynchronous FIFO.
// Keeps a binary read pointer for RAM addressing and a Gray copy for the write-side synchronizer.
module read_ptr_block #(
  parameter int unsigned PTR_W = 4
) (
  input  logic             r_clk,
  input  logic             rrst,
  input  logic             r_en,
  input  logic [PTR_W-1:0] g_wptr_sync,
  output logic [PTR_W-1:0] g_rptr,
  output logic [PTR_W-1:0] b_rptr,
  output logic             empty
);

  logic [PTR_W-1:0] b_rptr_q, b_rptr_d;
  logic [PTR_W-1:0] g_rptr_q, g_rptr_d;
  logic             empty_q, empty_d;
  logic             rd_ok;

  always_comb begin
    rd_ok    = r_en & ~empty_q;
    b_rptr_d = b_rptr_q + {{(PTR_W-1){1'b0}}, rd_ok};
    g_rptr_d = b_rptr_d ^ (b_rptr_d >> 1);
    // Full-width compare: a differing wrap bit means full, not empty.
    empty_d  = (g_rptr_d == g_wptr_sync);
  end

  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst) begin
      b_rptr_q <= '0;
      g_rptr_q <= '0;
      empty_q  <= 1'b1;
    end else begin
      b_rptr_q <= b_rptr_d;
      g_rptr_q <= g_rptr_d;
      empty_q  <= empty_d;
    end
  end

  assign b_rptr = b_rptr_q;
  assign g_rptr = g_rptr_q;
  assign empty  = empty_q;

endmodule

// File: tb/tb_read_ptr_block.sv
// Self-checking bench for read_ptr_block: vector table, corner sequences and a randomized run
// against a count-based model of the read side.
module tb_read_ptr_block;
  localparam int unsigned PTR_W = 4;

  logic             r_clk;
  logic             rrst;
  logic             r_en;
  logic [PTR_W-1:0] g_wptr_sync;
  logic [PTR_W-1:0] g_rptr;
  logic [PTR_W-1:0] b_rptr;
  logic             empty;

  int checks;
  int errors;

  // Model state: read count, write count (both mod 16) and the empty flag.
  int mb;
  int mwb;
  bit memp;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] wbin;
    logic [3:0] eb;
    logic [3:0] eg;
    logic       ee;
  } vec_t;

  vec_t vecs[13];

  read_ptr_block #(.PTR_W(PTR_W)) dut (
    .r_clk       (r_clk),
    .rrst        (rrst),
    .r_en        (r_en),
    .g_wptr_sync (g_wptr_sync),
    .g_rptr      (g_rptr),
    .b_rptr      (b_rptr),
    .empty       (empty)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, advance model, compare just after the rising edge.
  task automatic step(input bit rst, input bit en, input int wbin, input string name);
    @(negedge r_clk);
    rrst        = rst;
    r_en        = en;
    mwb         = wbin & 15;
    g_wptr_sync = gray(mwb);
    if (rst) begin
      mb   = 0;
      memp = 1'b1;
    end else begin
      if (en && !memp) mb = (mb + 1) & 15;
      memp = (mb == mwb);
    end
    @(posedge r_clk);
    #1;
    chk({name, "_b"}, 32'(b_rptr), 32'(mb));
    chk({name, "_g"}, 32'(g_rptr), 32'(gray(mb)));
    chk({name, "_empty"}, 32'(empty), 32'(memp));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    mb          = 0;
    mwb         = 0;
    memp        = 1'b1;
    rrst        = 1'b1;
    r_en        = 1'b0;
    g_wptr_sync = '0;

    // Asynchronous reset visible before any clock edge.
    #1;
    chk("rst_async_b", 32'(b_rptr), 32'd0);
    chk("rst_async_g", 32'(g_rptr), 32'd0);
    chk("rst_async_empty", 32'(empty), 32'd1);

    vecs[0]  = '{1'b1, 1'b0, 4'd6, 4'd0, 4'b0000, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 4'd6, 4'd0, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'd6, 4'd1, 4'b0001, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'd6, 4'd2, 4'b0011, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'd6, 4'd3, 4'b0010, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'd6, 4'd4, 4'b0110, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'd6, 4'd5, 4'b0111, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd6, 4'd6, 4'b0101, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 4'd6, 4'd6, 4'b0101, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 4'd0, 4'd0, 4'b0000, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 4'd0, 4'd0, 4'b0000, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 4'd0, 4'd0, 4'b0000, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 4'd0, 4'd0, 4'b0000, 1'b1};

    for (int i = 0; i < 13; i++) begin
      @(negedge r_clk);
      rrst        = vecs[i].rst;
      r_en        = vecs[i].en;
      g_wptr_sync = gray(int'(vecs[i].wbin));
      @(posedge r_clk);
      #1;
      chk($sformatf("vec%0d_b", i), 32'(b_rptr), 32'(vecs[i].eb));
      chk($sformatf("vec%0d_g", i), 32'(g_rptr), 32'(vecs[i].eg));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].ee));
    end

    // Wrap-around with the write pointer always one ahead of the post-read pointer.
    step(1'b1, 1'b0, 1, "wrap_rst");
    step(1'b0, 1'b0, 1, "wrap_rel");
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, mb + 2, "wrap");
      chk("wrap_noempty", 32'(empty), 32'd0);
      if (i == 14) begin
        chk("wrap_b15", 32'(b_rptr), 32'd15);
        chk("wrap_g15", 32'(g_rptr), 32'b1000);
      end
      if (i == 15) begin
        chk("wrap_b0", 32'(b_rptr), 32'd0);
        chk("wrap_g0", 32'(g_rptr), 32'b0000);
      end
    end
    // Full: same address bits, opposite wrap bit.
    step(1'b0, 1'b0, mb + 8, "full");
    chk("full_noempty", 32'(empty), 32'd0);
    step(1'b0, 1'b0, mb + 8, "full2");

    // Mid-operation reset between clock edges.
    step(1'b1, 1'b0, 5, "mid_rst");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 5, "mid_rd");
    chk("mid_pre_b", 32'(b_rptr), 32'd3);
    @(posedge r_clk);
    #2;
    rrst = 1'b1;
    #1;
    chk("mid_async_b", 32'(b_rptr), 32'd0);
    chk("mid_async_g", 32'(g_rptr), 32'd0);
    chk("mid_async_empty", 32'(empty), 32'd1);
    mb   = 0;
    memp = 1'b1;
    step(1'b0, 1'b0, 5, "mid_rel");

    // Randomized traffic with the write pointer kept at most a FIFO depth ahead.
    step(1'b1, 1'b0, 0, "rnd_rst");
    for (int i = 0; i < 400; i++) begin
      bit rst_r;
      bit en_r;
      int w;
      rst_r = ($urandom_range(0, 79) == 0);
      en_r  = ($urandom_range(0, 2) != 0);
      w     = mwb;
      if ($urandom_range(0, 1) == 1 && (((mwb - mb) & 15) < 8)) w = (mwb + 1) & 15;
      step(rst_r, en_r, w, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
